// File: rtl/fproc_meas_if.sv
// Bus bundle for fproc_meas: processor fproc request/response port plus the measurement
// result stream. The master drives requests and results; the slave is fproc_meas.
interface fproc_meas_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   fproc_id;
    logic                  fproc_en;
    logic                  fproc_ready;
    logic [DATA_WIDTH-1:0] fproc_data;
    logic                  busy;
    logic                  meas_valid;
    logic [ID_WIDTH-1:0]   meas_core;
    logic                  meas_bit;

    modport master (
        output fproc_id, fproc_en, meas_valid, meas_core, meas_bit,
        input  fproc_ready, fproc_data, busy
    );

    modport slave (
        input  fproc_id, fproc_en, meas_valid, meas_core, meas_bit,
        output fproc_ready, fproc_data, busy
    );
endinterface

// File: rtl/fproc_meas.sv
// Holds the latest measurement bit per source and answers fproc read requests, waiting for a
// fresh result when none is unread. Optional wait timeout under `FPROC_MEAS_TIMEOUT_EN`.
module fproc_meas #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned N_CORES    = 8,
    parameter int unsigned TIMEOUT    = 1024
) (
    input logic         clk,
    input logic         reset,
    fproc_meas_if.slave bus
);
    localparam int unsigned IdxW = $clog2(N_CORES);
    localparam logic [ID_WIDTH:0] NCores = (ID_WIDTH + 1)'(N_CORES);

    if (N_CORES < 2 || N_CORES > (1 << ID_WIDTH) || TIMEOUT == 0) begin : g_param_check
        $error("fproc_meas: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [DATA_WIDTH-1:0] resp_q, resp_d;
    logic [N_CORES-1:0]    bits_q, bits_d;
    logic [N_CORES-1:0]    flags_q, flags_d;

    logic            meas_in_range, req_in_range, same_cycle_hit;
    logic [IdxW-1:0] meas_idx, req_idx, wait_idx;

    assign meas_in_range  = {1'b0, bus.meas_core} < NCores;
    assign req_in_range   = {1'b0, bus.fproc_id} < NCores;
    assign meas_idx       = bus.meas_core[IdxW-1:0];
    assign req_idx        = bus.fproc_id[IdxW-1:0];
    assign wait_idx       = id_q[IdxW-1:0];
    assign same_cycle_hit = bus.meas_valid && (bus.meas_core == bus.fproc_id);

`ifdef FPROC_MEAS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only runs in WAIT, so it is zero on every entry into WAIT.
    always_comb begin
        cnt_d = '0;
        if (state_q == StWait) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            id_q    <= '0;
            resp_q  <= '0;
            bits_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            resp_q  <= resp_d;
            bits_q  <= bits_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        resp_d  = resp_q;
        bits_d  = bits_q;
        flags_d = flags_q;

        // Store first; a read of the same source below then consumes it.
        if (bus.meas_valid && meas_in_range) begin
            bits_d[meas_idx]  = bus.meas_bit;
            flags_d[meas_idx] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.fproc_en) begin
                    id_d = bus.fproc_id;
                    if (!req_in_range) begin
                        state_d = StResp;
                        resp_d  = '0;
                    end else if (same_cycle_hit) begin
                        state_d          = StResp;
                        resp_d           = {{(DATA_WIDTH - 1){1'b0}}, bus.meas_bit};
                        flags_d[req_idx] = 1'b0;
                    end else if (flags_q[req_idx]) begin
                        state_d          = StResp;
                        resp_d           = {{(DATA_WIDTH - 1){1'b0}}, bits_q[req_idx]};
                        flags_d[req_idx] = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (bus.meas_valid && (bus.meas_core == id_q)) begin
                    state_d           = StResp;
                    resp_d            = {{(DATA_WIDTH - 1){1'b0}}, bus.meas_bit};
                    flags_d[wait_idx] = 1'b0;
                end
`ifdef FPROC_MEAS_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    resp_d  = '1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus.fproc_ready = (state_q == StResp);
        bus.fproc_data  = (state_q == StResp) ? resp_q : '0;
        bus.busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_fproc_meas.sv
// Self-checking bench for fproc_meas: directed scenarios plus a randomized run against a
// transaction-level model of per-source bit/unread-flag storage.
`timescale 1ns/1ps
module tb_fproc_meas;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 8;
    localparam int unsigned NC = 8;
    localparam int unsigned TO = 16;

    localparam logic [33:0] IDLE_O = 34'd0;
    localparam logic [33:0] WAIT_O = {2'b01, 32'd0};

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_bit[NC];
    bit   m_flag[NC];

    fproc_meas_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    fproc_meas #(
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .N_CORES   (NC),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic logic [33:0] outs();
        return {bus.fproc_ready, bus.busy, bus.fproc_data};
    endfunction

    function automatic logic [33:0] resp_o(input logic [31:0] d);
        return {2'b11, d};
    endfunction

    task automatic idle_inputs();
        bus.fproc_en   = 1'b0;
        bus.fproc_id   = '0;
        bus.meas_valid = 1'b0;
        bus.meas_core  = '0;
        bus.meas_bit   = 1'b0;
    endtask

    // One clock cycle with the given inputs; outputs are then sampled 1ns after the edge.
    task automatic drive(input bit en, input int id, input bit mv, input int core, input bit b);
        bus.fproc_en   = en;
        bus.fproc_id   = IW'(id);
        bus.meas_valid = mv;
        bus.meas_core  = IW'(core);
        bus.meas_bit   = b;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (outs() !== IDLE_O) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", outs(), IDLE_O);
        end
        reset = 1'b0;
        drive(1, 0, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL first_cycle_request: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 0, 1);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL first_cycle_resp: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        drive(0, 0, 1, 3, 1);
        n_tests++;
        if (outs() !== IDLE_O) begin
            n_fail++;
            $display("FAIL basic_meas_idle: got %h want %h", outs(), IDLE_O);
        end
        repeat (2) drive(0, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL basic_resp: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        n_tests++;
        if (outs() !== IDLE_O) begin
            n_fail++;
            $display("FAIL basic_one_cycle: got %h want %h", outs(), IDLE_O);
        end
        drive(1, 3, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL basic_flag_cleared: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 3, 0);
        n_tests++;
        if (outs() !== resp_o(0)) begin
            n_fail++;
            $display("FAIL basic_wait_resp: got %h want %h", outs(), resp_o(0));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_wait();
        drive(1, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(0, 0, 1, 6, 1);
            else drive(0, 0, 0, 0, 0);
            n_tests++;
            if (outs() !== WAIT_O) begin
                n_fail++;
                $display("FAIL wait_busy[%0d]: got %h want %h", i, outs(), WAIT_O);
            end
        end
        drive(0, 0, 1, 5, 1);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL wait_resp: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 6, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL wait_other_stored: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_out_of_range();
        drive(0, 0, 1, 200, 1);
        drive(1, 200, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(0)) begin
            n_fail++;
            $display("FAIL oor_id200: got %h want %h", outs(), resp_o(0));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(0)) begin
            n_fail++;
            $display("FAIL oor_id8: got %h want %h", outs(), resp_o(0));
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 7, 1);
        drive(1, 7, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL range_id7: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 11, 1);
        drive(1, 3, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL oor_no_alias: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 3, 1);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_overwrite();
        drive(0, 0, 1, 2, 0);
        drive(0, 0, 1, 2, 1);
        drive(1, 2, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL overwrite_resp: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL overwrite_second_waits: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 2, 0);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_same_cycle();
        drive(1, 4, 1, 4, 1);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL same_src_resp: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL same_src_consumed: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 4, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 6, 0);
        drive(1, 6, 1, 7, 1);
        n_tests++;
        if (outs() !== resp_o(0)) begin
            n_fail++;
            $display("FAIL diff_src_resp: got %h want %h", outs(), resp_o(0));
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 7, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL diff_src_kept: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 5, 0);
        drive(1, 5, 1, 5, 1);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL same_src_newest: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_ignore_busy();
        drive(0, 0, 1, 2, 1);
        drive(1, 1, 0, 0, 0);
        drive(1, 2, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL busy_ignore_en: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 1, 1);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL busy_resp_orig_id: got %h want %h", outs(), resp_o(1));
        end
        drive(1, 2, 0, 0, 0);
        n_tests++;
        if (outs() !== IDLE_O) begin
            n_fail++;
            $display("FAIL resp_ignore_en: got %h want %h", outs(), IDLE_O);
        end
        drive(1, 2, 0, 0, 0);
        n_tests++;
        if (outs() !== resp_o(1)) begin
            n_fail++;
            $display("FAIL busy_flag_kept: got %h want %h", outs(), resp_o(1));
        end
        drive(0, 0, 0, 0, 0);
    endtask

`ifdef FPROC_MEAS_TIMEOUT_EN
    task automatic test_timeout();
        int cycles = 0;
        drive(1, 4, 0, 0, 0);
        while (bus.fproc_ready !== 1'b1 && cycles < 100) begin
            drive(0, 0, 0, 0, 0);
            cycles++;
        end
        n_tests++;
        if (cycles != TO) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d want %0d", cycles, TO);
        end
        n_tests++;
        if (outs() !== resp_o(32'hFFFF_FFFF)) begin
            n_fail++;
            $display("FAIL timeout_data: got %h want %h", outs(), resp_o(32'hFFFF_FFFF));
        end
        drive(0, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_reset_in_wait();
        drive(0, 0, 1, 1, 1);
        drive(1, 6, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (outs() !== IDLE_O) begin
            n_fail++;
            $display("FAIL async_reset_wait: got %h want %h", outs(), IDLE_O);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (m_flag[i]) begin
            m_flag[i] = 1'b0;
            m_bit[i]  = 1'b0;
        end
        drive(1, 1, 0, 0, 0);
        n_tests++;
        if (outs() !== WAIT_O) begin
            n_fail++;
            $display("FAIL reset_clears_flag: got %h want %h", outs(), WAIT_O);
        end
        drive(0, 0, 1, 1, 0);
        n_tests++;
        if (outs() !== resp_o(0)) begin
            n_fail++;
            $display("FAIL post_reset_resp: got %h want %h", outs(), resp_o(0));
        end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 150; it++) begin
            int          id, core;
            bit          mv, b, waiting;
            logic [33:0] exp;
            repeat ($urandom_range(0, 3)) begin
                core = $urandom_range(0, 11);
                b    = 1'($urandom_range(0, 1));
                mv   = 1'($urandom_range(0, 1));
                drive(0, 0, mv, core, b);
                if (mv && core < NC) begin
                    m_bit[core]  = b;
                    m_flag[core] = 1'b1;
                end
            end
            id   = $urandom_range(0, 9);
            mv   = 1'($urandom_range(0, 1));
            core = ($urandom_range(0, 3) == 0) ? id : $urandom_range(0, 11);
            b    = 1'($urandom_range(0, 1));
            drive(1, id, mv, core, b);
            if (mv && core < NC) begin
                m_bit[core]  = b;
                m_flag[core] = 1'b1;
            end
            waiting = 1'b0;
            if (id >= NC) begin
                exp = resp_o(0);
            end else if (m_flag[id]) begin
                exp        = resp_o({31'd0, m_bit[id]});
                m_flag[id] = 1'b0;
            end else begin
                exp     = WAIT_O;
                waiting = 1'b1;
            end
            n_tests++;
            if (outs() !== exp) begin
                n_fail++;
                $display("FAIL rand_req[%0d] id=%0d: got %h want %h", it, id, outs(), exp);
            end
            if (waiting) begin
                repeat ($urandom_range(0, 4)) begin
                    core = $urandom_range(0, 11);
                    if (core == id) core = id + 1;
                    b = 1'($urandom_range(0, 1));
                    drive(0, 0, 1, core, b);
                    if (core < NC) begin
                        m_bit[core]  = b;
                        m_flag[core] = 1'b1;
                    end
                end
                b = 1'($urandom_range(0, 1));
                drive(0, 0, 1, id, b);
                m_bit[id] = b;
                n_tests++;
                if (outs() !== resp_o({31'd0, b})) begin
                    n_fail++;
                    $display("FAIL rand_wait_resp[%0d] id=%0d: got %h want %h", it, id, outs(),
                             resp_o({31'd0, b}));
                end
            end
            mv   = 1'($urandom_range(0, 1));
            core = $urandom_range(0, 11);
            b    = 1'($urandom_range(0, 1));
            drive(0, 0, mv, core, b);
            if (mv && core < NC) begin
                m_bit[core]  = b;
                m_flag[core] = 1'b1;
            end
            n_tests++;
            if (outs() !== IDLE_O) begin
                n_fail++;
                $display("FAIL rand_back_idle[%0d]: got %h want %h", it, outs(), IDLE_O);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_wait();
        test_out_of_range();
        test_overwrite();
        test_same_cycle();
        test_ignore_busy();
`ifdef FPROC_MEAS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fproc_meas.md
FPROC_MEAS -- requirements
Module: fproc_meas

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the response data word.
REQ-002 SHALL have parameter ID_WIDTH, default 8, width of the fproc request id.
REQ-003 SHALL have parameter N_CORES, default 8, number of measurement sources held (2..2^ID_WIDTH).
REQ-004 SHALL have parameter TIMEOUT, default 1024, maximum wait cycles (used only with FPROC_MEAS_TIMEOUT_EN).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-006 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have fproc_id  input  ID_WIDTH  id of the requested measurement source, sampled with fproc_en.
REQ-008 SHALL have fproc_en  input  1  one-cycle request strobe from the processor's fproc port.
REQ-009 SHALL have meas_valid  input  1  one-cycle strobe: a new measurement result is present.
REQ-010 SHALL have meas_core  input  ID_WIDTH  source index of the measurement.
REQ-011 SHALL have meas_bit  input  1  measurement result bit.
REQ-012 SHALL have fproc_ready  output  1  one-cycle response strobe back to the processor.
REQ-013 SHALL have fproc_data  output  DATA_WIDTH  response word, valid only while fproc_ready=1.
REQ-014 SHALL have busy  output  1  high while a request is outstanding (states WAIT, RESP).

Function
REQ-015 SHALL keep per-source storage: bit[N_CORES] and flag[N_CORES] (flag = unread result present).
REQ-016 SHALL, on meas_valid with meas_core<N_CORES, write bit[meas_core]=meas_bit and set flag[meas_core]; meas_core>=N_CORES ignored.
REQ-017 SHALL overwrite bit and keep flag set when a second result arrives for a source whose flag is already set.
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-019 SHALL, in IDLE with fproc_en=1, latch fproc_id; if id>=N_CORES go to RESP with data 0.
REQ-020 SHALL, in IDLE with fproc_en=1, id<N_CORES and flag[id]=1 (or meas_valid for id that cycle), go to RESP with that bit and clear flag[id].
REQ-021 SHALL otherwise go IDLE->WAIT; in WAIT, on meas_valid with meas_core=latched id, go to RESP with meas_bit and leave flag[id] clear (consumed).
REQ-022 SHALL, in RESP, assert fproc_ready=1 for exactly one cycle with fproc_data = result zero-extended to DATA_WIDTH, then return to IDLE.
REQ-023 SHALL give latency: request at cycle N with result present -> fproc_ready at N+1; result arriving at cycle M in WAIT -> fproc_ready at M+1.
REQ-024 SHALL ignore fproc_en while busy=1 (no queuing, no state change).
REQ-025 SHALL drive fproc_data=0 whenever fproc_ready=0.
REQ-026 SHALL give the same-cycle meas_valid write priority over a flag clear on a different source; on the same source the read consumes it (flag ends clear).

Reset
REQ-027 SHALL, on reset (asynchronous, any state incl. WAIT/RESP), force IDLE, clear all flags and bits, fproc_ready=0, fproc_data=0, busy=0.
REQ-028 SHALL accept a new request in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL compile a wait timeout only when macro FPROC_MEAS_TIMEOUT_EN is defined.
REQ-030 SHALL, with FPROC_MEAS_TIMEOUT_EN, count WAIT cycles; when the count reaches TIMEOUT go to RESP with fproc_data all ones; counter clears on entering WAIT.
REQ-031 SHALL, without FPROC_MEAS_TIMEOUT_EN, wait in WAIT indefinitely and contain no counter.

Verification
REQ-032 SHALL verify: meas_valid core=3 bit=1, later fproc_en id=3 -> fproc_ready 1 cycle later, fproc_data=1, flag[3] cleared.
REQ-033 SHALL verify: fproc_en id=5 with no result, meas_valid core=5 bit=1 6 cycles later -> fproc_ready the next cycle, data=1, busy high throughout the wait.
REQ-034 SHALL verify: fproc_en id=200 (N_CORES=8) -> fproc_ready next cycle, data=0.
REQ-035 SHALL verify: meas core=2 bit=0 then core=2 bit=1, request id=2 -> data=1; second request id=2 -> enters WAIT.
REQ-036 SHALL verify: reset asserted in WAIT -> outputs 0, state IDLE; after release request id=1 with no result -> WAIT.
REQ-037 SHALL verify (FPROC_MEAS_TIMEOUT_EN, TIMEOUT=16): request id=4 with no result -> fproc_ready after 16 WAIT cycles, data=0xFFFFFFFF.
